// File: rtl/rv32_data_mem_responder.sv
// RV32I data-memory responder: accepts load/store requests against an
// on-chip word array, steers byte/half/word lanes, extends load data and
// returns one in-order response per accepted request after RD_LATENCY cycles.
// After reset the array is zero-filled one word per cycle before requests
// are accepted.
module rv32_data_mem_responder #(
  parameter int DEPTH_WORDS    = 1024,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clrIdx_q, clrIdx_d;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic [ADDR_W-1:0] widx;
  logic [1:0]        off;
  logic              decErr;
  logic              storeEn;
  logic [31:0]       rdWord;
  logic [15:0]       loadLane;
  logic [31:0]       loadData;
  logic [3:0]        byteEn;
  logic [31:0]       laneData;
  logic [31:0]       bitMask;

  logic              pipeValid_q [RD_LATENCY];
  logic [31:0]       pipeData_q  [RD_LATENCY];
  logic              pipeErr_q   [RD_LATENCY];

  // ready is forced low while reset is held, even when the FSM resets to READY
  assign req_ready = (state_q == ST_READY) && rst_n;
  assign busy      = (state_q == ST_CLEAR);
  assign accept    = req_valid && req_ready;
  assign widx      = req_addr[ADDR_W+1:2];
  assign off       = req_addr[1:0];
  assign storeEn   = accept && req_write && !decErr;
  assign rdWord    = mem[widx];

  // Request decode: illegal size, misalignment, or beyond the byte span
  always_comb begin
    decErr = 1'b0;
    case (req_size)
      2'b00:   decErr = 1'b0;
      2'b01:   decErr = off[0];
      2'b10:   decErr = (off != 2'b00);
      default: decErr = 1'b1;
    endcase
    if ({1'b0, req_addr} >= BYTE_SPAN) decErr = 1'b1;
  end

  // Store lane steering: replicate data across lanes and enable only the target bytes
  always_comb begin
    byteEn   = 4'b0000;
    laneData = req_wdata;
    case (req_size)
      2'b00: begin
        byteEn   = 4'b0001 << off;
        laneData = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byteEn   = 4'b0011 << off;
        laneData = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        byteEn   = 4'b1111;
        laneData = req_wdata;
      end
      default: byteEn = 4'b0000;
    endcase
    bitMask = '0;
    for (int b = 0; b < 4; b++) bitMask[8*b +: 8] = {8{byteEn[b]}};
  end

  // Load extraction: shift the addressed lane down, then sign or zero extend
  always_comb begin
    loadLane = 16'(rdWord >> {off, 3'b000});
    loadData = '0;
    if (!req_write && !decErr) begin
      case (req_size)
        2'b00:   loadData = req_unsigned ? {24'b0, loadLane[7:0]}
                                         : {{24{loadLane[7]}}, loadLane[7:0]};
        2'b01:   loadData = req_unsigned ? {16'b0, loadLane}
                                         : {{16{loadLane[15]}}, loadLane};
        2'b10:   loadData = rdWord;
        default: loadData = '0;
      endcase
    end
  end

  // Word array: clear sweep has priority, otherwise merge store lanes into the old word
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clrIdx_q] <= '0;
    end else if (storeEn) begin
      mem[widx] <= (rdWord & ~bitMask) | (laneData & bitMask);
    end
  end

  // FSM next state: walk the clear index up to the last word, then settle in READY
  always_comb begin
    state_d  = state_q;
    clrIdx_d = clrIdx_q;
    case (state_q)
      ST_CLEAR: begin
        clrIdx_d = clrIdx_q + 1'b1;
        if (clrIdx_q == ADDR_W'(DEPTH_WORDS - 1)) state_d = ST_READY;
      end
      default: state_d = ST_READY;
    endcase
  end

  // FSM state register; reset restarts the clear sweep from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clrIdx_q <= '0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
    end
  end

  // Response pipeline: valid shifts every cycle, payload only moves with a valid
  // entry so the final stage holds the last response while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeData_q[i]  <= '0;
        pipeErr_q[i]   <= 1'b0;
      end
    end else begin
      pipeValid_q[0] <= accept;
      if (accept) begin
        pipeData_q[0] <= loadData;
        pipeErr_q[0]  <= decErr;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        if (pipeValid_q[i-1]) begin
          pipeData_q[i] <= pipeData_q[i-1];
          pipeErr_q[i]  <= pipeErr_q[i-1];
        end
      end
    end
  end

  assign rsp_valid = pipeValid_q[RD_LATENCY-1];
  assign rsp_rdata = pipeData_q[RD_LATENCY-1];
  assign rsp_err   = pipeErr_q[RD_LATENCY-1];

endmodule

// File: tb/tb_rv32_data_mem_responder.sv
// Directed bench for rv32_data_mem_responder with a 16-word array and a
// three-cycle response latency.
module tb_rv32_data_mem_responder;

  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  rv32_data_mem_responder #(
    .DEPTH_WORDS   (DEPTH),
    .RD_LATENCY    (LAT),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request, wait for its response; lat counts edges after the accept edge
  task automatic transact(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  // Hold reset, check reset outputs, release and count busy cycles of the clear sweep
  task automatic test_reset();
    int cnt;
    logic [31:0] rd; logic er; int lat;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0", req_ready); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=1", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    rst_n = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && req_ready === 1'b0 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    total++; if (cnt !== DEPTH) begin bad++; $display("[TB] FAIL clear_cycles got=%0d exp=%0d", cnt, DEPTH); end
    total++; if (req_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("[TB] FAIL ready_after_clear got=%b/%b exp=1/0", req_ready, busy); end
    transact(1'b0, 2'b10, 1'b0, 32'h3C, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("[TB] FAIL load_3c got=%h/%b exp=00000000/0", rd, er); end
  endtask

  // Word store then word load, including response latency
  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("[TB] FAIL sw_rsp got=%h/%b exp=00000000/0", rd, er); end
    total++; if (lat !== LAT - 1) begin bad++; $display("[TB] FAIL sw_latency got=%0d exp=%0d", lat, LAT - 1); end
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("[TB] FAIL lw_10 got=%h/%b exp=deadbeef/0", rd, er); end
    total++; if (lat !== LAT - 1) begin bad++; $display("[TB] FAIL lw_latency got=%0d exp=%0d", lat, LAT - 1); end
  endtask

  // Byte store into a word, then word, signed and unsigned byte loads
  task automatic test_bytes();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
    transact(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, rd, er, lat);
    transact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h11AA3344) begin bad++; $display("[TB] FAIL lw_20 got=%h exp=11aa3344", rd); end
    transact(1'b0, 2'b00, 1'b0, 32'h22, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFFFFAA || er !== 1'b0) begin bad++; $display("[TB] FAIL lb_22 got=%h exp=ffffffaa", rd); end
    transact(1'b0, 2'b00, 1'b1, 32'h22, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h000000AA) begin bad++; $display("[TB] FAIL lbu_22 got=%h exp=000000aa", rd); end
    transact(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00000044) begin bad++; $display("[TB] FAIL lb_20 got=%h exp=00000044", rd); end
    transact(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00000011) begin bad++; $display("[TB] FAIL lb_23 got=%h exp=00000011", rd); end
  endtask

  // Upper-half store, then signed/unsigned half loads and the containing word
  task automatic test_halves();
    logic [31:0] rd; logic er; int lat;
    transact(1'b1, 2'b01, 1'b0, 32'h32, 32'h00008001, rd, er, lat);
    transact(1'b0, 2'b01, 1'b0, 32'h32, 32'h0, rd, er, lat);
    total++; if (rd !== 32'hFFFF8001 || er !== 1'b0) begin bad++; $display("[TB] FAIL lh_32 got=%h exp=ffff8001", rd); end
    transact(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00008001) begin bad++; $display("[TB] FAIL lhu_32 got=%h exp=00008001", rd); end
    transact(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h80010000) begin bad++; $display("[TB] FAIL lw_30 got=%h exp=80010000", rd); end
    transact(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00000000) begin bad++; $display("[TB] FAIL lh_30 got=%h exp=00000000", rd); end
  endtask

  // Rejected requests: error flag, zero data, and no memory side effects
  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    transact(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL err_lw_21 got=%h/%b exp=00000000/1", rd, er); end
    transact(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL err_lh_23 got=%h/%b exp=00000000/1", rd, er); end
    transact(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL err_size11 got=%h/%b exp=00000000/1", rd, er); end
    transact(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("[TB] FAIL err_lw_range got=%h/%b exp=00000000/1", rd, er); end
    transact(1'b1, 2'b10, 1'b0, 32'h40, 32'h55555555, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("[TB] FAIL err_sw_range got=%b exp=1", er); end
    transact(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000BBBB, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("[TB] FAIL err_sh_21 got=%b exp=1", er); end
    transact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h11AA3344 || er !== 1'b0) begin bad++; $display("[TB] FAIL err_mem20 got=%h/%b exp=11aa3344/0", rd, er); end
    transact(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h00000000) begin bad++; $display("[TB] FAIL err_mem00 got=%h exp=00000000", rd); end
  endtask

  // Three back-to-back loads, then a store followed next cycle by a load of the same word
  task automatic test_back_to_back();
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_wdata = '0;
    req_valid = 1'b1; req_addr = 32'h10;
    @(posedge clk); #1; req_addr = 32'h20;
    @(posedge clk); #1; req_addr = 32'h30;
    @(posedge clk); #1; req_valid = 1'b0;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL b2b_rsp0 got=%b/%h exp=1/deadbeef", rsp_valid, rsp_rdata); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11AA3344) begin bad++; $display("[TB] FAIL b2b_rsp1 got=%b/%h exp=1/11aa3344", rsp_valid, rsp_rdata); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80010000) begin bad++; $display("[TB] FAIL b2b_rsp2 got=%b/%h exp=1/80010000", rsp_valid, rsp_rdata); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h80010000) begin bad++; $display("[TB] FAIL b2b_idle_hold got=%b/%h exp=0/80010000", rsp_valid, rsp_rdata); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h14; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1; req_write = 1'b0; req_wdata = '0;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("[TB] FAIL haz_store_rsp got=%b/%h exp=1/00000000", rsp_valid, rsp_rdata); end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL haz_load_rsp got=%b/%h exp=1/cafef00d", rsp_valid, rsp_rdata); end
  endtask

  // Reset with loads in flight: nothing emerges and the clear sweep restarts
  task automatic test_reset_midflight();
    int cnt;
    int seenValid;
    logic [31:0] rd; logic er; int lat;
    req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_valid = 1'b1; req_addr = 32'h10;
    @(posedge clk); #1; req_addr = 32'h20;
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 1'b0;
    seenValid = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seenValid++;
    end
    rst_n = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (rsp_valid !== 1'b0) seenValid++;
      @(posedge clk); #1;
      cnt++;
    end
    total++; if (seenValid !== 0) begin bad++; $display("[TB] FAIL midflight_rsp got=%0d valid cycles exp=0", seenValid); end
    total++; if (cnt !== DEPTH) begin bad++; $display("[TB] FAIL reclear_cycles got=%0d exp=%0d", cnt, DEPTH); end
    transact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    total++; if (rd !== 32'h0 || lat !== LAT - 1) begin bad++; $display("[TB] FAIL reclear_mem10 got=%h lat=%0d exp=00000000 lat=%0d", rd, lat, LAT - 1); end
  endtask

  // Run all scenarios in order, then report
  initial begin
    test_reset();
    test_word();
    test_bytes();
    test_halves();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
